// File: rtl/clock_pkg.sv
// clock_pkg: shared widths, limits and edit-state encoding for the clock-set controller.
//   HOUR_W/MIN_W/SEC_W : field widths
//   MAX_MINSEC         : wrap limit for minutes and seconds
//   state_t            : RUN=0, SET_H=1, SET_M=2, SET_S=3 (driven directly on mode)
package clock_pkg;

    localparam int HOUR_W     = 5;
    localparam int MIN_W      = 6;
    localparam int SEC_W      = 6;
    localparam int MAX_MINSEC = 59;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    // Blank-mask bit of the field being edited, ordered {hour,min,sec}.
    function automatic logic [2:0] field_mask(input state_t s);
        return (s == SET_H) ? 3'b100 : (s == SET_M) ? 3'b010 : (s == SET_S) ? 3'b001 : 3'b000;
    endfunction

endpackage

// File: rtl/clock_field_adj.sv
// clock_field_adj: one wrapping up/down time field with clamped parallel load.
//   clk, rst : clock, synchronous active-high reset (value -> 0)
//   ld       : load ld_val, clamped to LIMIT (has priority over inc/dec)
//   inc/dec  : step up/down with wrap LIMIT<->0 (caller keeps them exclusive)
//   val      : registered field value, always within 0..LIMIT
module clock_field_adj #(
    parameter int W     = 6,
    parameter int LIMIT = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] val
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] val_q, val_d;

    always_comb begin
        val_d = ld  ? ((ld_val > LIM) ? LIM : ld_val) :
                inc ? ((val_q >= LIM) ? '0 : val_q + 1'b1) :
                dec ? ((val_q == '0 || val_q > LIM) ? LIM : val_q - 1'b1) :
                val_q;
    end

    always_ff @(posedge clk) begin
        if (rst) val_q <= '0;
        else     val_q <= val_d;
    end

    assign val = val_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: key-driven time-setting FSM with per-field blink and optional idle timeout.
//   clk, rstn              : clock, synchronous active-high reset (rstn=1 resets)
//   key_mode/inc/dec       : single-cycle key pulses (advance field / adjust)
//   tick_ms                : 1 ms strobe for blink and timeout
//   cur_hour/min/sec       : live time, captured on entry to edit
//   set_hour/min/sec, load : edited time and one-cycle commit strobe
//   run_en, blank, mode    : counter enable, {hour,min,sec} blank mask, state
// Define CLOCK_SET_TIMEOUT_EN to return to RUN (without load) after TIMEOUT_MS idle ticks.
module clock_set_ctrl import clock_pkg::*; #(
    parameter int MAX_HOUR   = 23,
    parameter int BLINK_DIV  = 250,
    parameter int TIMEOUT_MS = 10000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key_mode,
    input  logic              key_inc,
    input  logic              key_dec,
    input  logic              tick_ms,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    output logic [HOUR_W-1:0] set_hour,
    output logic [MIN_W-1:0]  set_min,
    output logic [SEC_W-1:0]  set_sec,
    output logic              load,
    output logic              run_en,
    output logic [2:0]        blank,
    output logic [1:0]        mode
);

    localparam int BW = $clog2(BLINK_DIV + 1);

    state_t        state_q, state_d;
    logic          run_en_q, run_en_d;
    logic          load_q, load_d;
    logic [2:0]    blank_q, blank_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          in_set, inc_ok, dec_ok, capture, blink_clr, blink_wrap, timeout;

    always_comb begin
        in_set  = state_q != RUN;
        // Mode wins over adjust, and simultaneous inc+dec cancel out.
        inc_ok  = in_set && !key_mode && key_inc && !key_dec;
        dec_ok  = in_set && !key_mode && key_dec && !key_inc;
        capture = (state_q == RUN) && key_mode;
        // The encoding makes "next field" a plain increment; SET_S+1 wraps to RUN.
        state_d = key_mode ? state_t'(state_q + 2'd1) : timeout ? RUN : state_q;
        load_d   = (state_q == SET_S) && key_mode;
        run_en_d = state_d == RUN;
        // Field shown solid on entering a field and after every accepted adjust.
        blink_clr  = (state_d == RUN) || (state_d != state_q) || inc_ok || dec_ok;
        blink_wrap = tick_ms && (blink_q == BW'(BLINK_DIV - 1));
        blink_d = blink_clr ? '0 : blink_wrap ? '0 : tick_ms ? blink_q + 1'b1 : blink_q;
        phase_d = blink_clr ? 1'b0 : blink_wrap ? ~phase_q : phase_q;
        blank_d = phase_d ? field_mask(state_d) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= RUN;
            run_en_q <= 1'b1;
            load_q   <= 1'b0;
            blank_q  <= 3'b000;
            blink_q  <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_en_q <= run_en_d;
            load_q   <= load_d;
            blank_q  <= blank_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
        end
    end

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_MS + 1);

    logic [TW-1:0] to_q, to_d;
    logic          key_any;

    always_comb begin
        key_any = key_mode || key_inc || key_dec;
        timeout = in_set && !key_any && tick_ms && (to_q == TW'(TIMEOUT_MS - 1));
        to_d    = (!in_set || key_any || timeout) ? '0 : tick_ms ? to_q + 1'b1 : to_q;
    end

    always_ff @(posedge clk) begin
        if (rstn) to_q <= '0;
        else      to_q <= to_d;
    end
`else
    assign timeout = 1'b0;
`endif

    clock_field_adj #(.W(HOUR_W), .LIMIT(MAX_HOUR)) u_hour (
        .clk    (clk),
        .rst    (rstn),
        .ld     (capture),
        .ld_val (cur_hour),
        .inc    (inc_ok && state_q == SET_H),
        .dec    (dec_ok && state_q == SET_H),
        .val    (set_hour)
    );

    clock_field_adj #(.W(MIN_W), .LIMIT(MAX_MINSEC)) u_min (
        .clk    (clk),
        .rst    (rstn),
        .ld     (capture),
        .ld_val (cur_min),
        .inc    (inc_ok && state_q == SET_M),
        .dec    (dec_ok && state_q == SET_M),
        .val    (set_min)
    );

    clock_field_adj #(.W(SEC_W), .LIMIT(MAX_MINSEC)) u_sec (
        .clk    (clk),
        .rst    (rstn),
        .ld     (capture),
        .ld_val (cur_sec),
        .inc    (inc_ok && state_q == SET_S),
        .dec    (dec_ok && state_q == SET_S),
        .val    (set_sec)
    );

    assign load   = load_q;
    assign run_en = run_en_q;
    assign blank  = blank_q;
    assign mode   = state_q;

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter MAX_HOUR, default 23, SHALL be the highest hour value; the hour field wraps at it.
REQ-002 Parameter BLINK_DIV, default 250, SHALL be the number of tick_ms strobes per blink half-period.
REQ-003 Parameter TIMEOUT_MS, default 10000, SHALL be the idle timeout in tick_ms strobes (used only under REQ-026).
REQ-004 Port list, one per line (name direction width meaning):
  clk  in  1  single system clock, all logic on rising edge
  rstn  in  1  reset, synchronous, active-high (1 = reset)
  key_mode  in  1  debounced single-cycle pulse, advance edit field
  key_inc  in  1  debounced single-cycle pulse, increment field
  key_dec  in  1  debounced single-cycle pulse, decrement field
  tick_ms  in  1  single-cycle 1 ms strobe
  cur_hour  in  5  live hour from time counter
  cur_min  in  6  live minute from time counter
  cur_sec  in  6  live second from time counter
  set_hour  out  5  edited hour value
  set_min  out  6  edited minute value
  set_sec  out  6  edited second value
  load  out  1  one-cycle strobe, time counter takes set_* values
  run_en  out  1  1 = time counter advances, 0 = paused
  blank  out  3  per-field display blank mask {hour,min,sec}, 1 = blank
  mode  out  2  current state encoding

Function
REQ-005 FSM states SHALL be RUN=0, SET_H=1, SET_M=2, SET_S=3, driven directly on mode.
REQ-006 In RUN: run_en=1, blank=000, set_* hold their last values, key_inc/key_dec ignored.
REQ-007 In RUN, key_mode SHALL go to SET_H next cycle, capture cur_hour/min/sec into set_*, and drop run_en to 0 in that same cycle.
REQ-008 key_mode SHALL step SET_H->SET_M->SET_S->RUN, one step per pulse.
REQ-009 On SET_S->RUN, load SHALL be 1 for exactly the one cycle in which state becomes RUN, and run_en SHALL return to 1 in that cycle.
REQ-010 In SET_x, key_inc SHALL add 1 to the active field, taking effect next cycle; hour wraps MAX_HOUR->0, min/sec wrap 59->0.
REQ-011 In SET_x, key_dec SHALL subtract 1 from the active field; hour wraps 0->MAX_HOUR, min/sec wrap 0->59.
REQ-012 When key_inc and key_dec are asserted in the same cycle, both SHALL be ignored.
REQ-013 When key_mode coincides with key_inc or key_dec, key_mode SHALL win and the adjust pulse is dropped.
REQ-014 Blink counter SHALL count tick_ms and toggle a phase bit every BLINK_DIV strobes; only the active field's blank bit follows phase, and the other bits are 0.
REQ-015 Entry to any SET_x state and every accepted inc/dec SHALL clear the blink counter and phase, so the field is shown solid.
REQ-016 set_* SHALL never exceed their wrap limits; out-of-range cur_* captured in REQ-007 SHALL be clamped to the limit.

Reset
REQ-017 While rstn=1 at a clk edge: state=RUN, run_en=1, load=0, blank=000, set_*=0, blink counter and phase=0, timeout counter=0.
REQ-018 Reset asserted mid-edit SHALL discard edits, with no load pulse.
REQ-019 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Configuration
REQ-020 Macro CLOCK_SET_TIMEOUT_EN SHALL enable the idle timeout.
REQ-021 With the macro defined: in SET_x, TIMEOUT_MS consecutive tick_ms strobes without any key pulse SHALL return to RUN with load=0 (edits discarded) and run_en=1; any key pulse clears the counter.
REQ-022 Without the macro: no timeout counter is synthesized, and SET_x persists indefinitely.

Structure
REQ-023 Shared package clock_pkg SHALL hold HOUR_W=5, MIN_W=6, SEC_W=6, MAX_MINSEC=59, and the state typedef and encoding of REQ-005.
REQ-024 Sub-module clock_field_adj (parameterized width and limit, wrapping up/down register with load and clamp) SHALL be instantiated once per field.
REQ-025 The blink logic and the FSM SHALL remain in clock_set_ctrl.
REQ-026 The timeout logic SHALL be guarded entirely by CLOCK_SET_TIMEOUT_EN.

Verification
REQ-027 cur=12:34:56, mode pulse, then 3 mode pulses -> load=1 for one cycle with set=12:34:56; run_en 0 during edit, 1 after.
REQ-028 SET_H with set_hour=23, inc -> 0; dec -> 23; SET_M with set_min=0, dec -> 59.
REQ-029 inc+dec in the same cycle -> value unchanged; mode+inc in the same cycle -> state advances, value unchanged.
REQ-030 SET_M, BLINK_DIV=4, 8 tick_ms -> blank toggles 000/010 each 4 ticks; an inc resets blank to 000.
REQ-031 Reset pulse in SET_S -> next cycle RUN, run_en=1, load never asserted, set_*=0.
REQ-032 With CLOCK_SET_TIMEOUT_EN and TIMEOUT_MS=5, 5 idle tick_ms in SET_H -> RUN, load=0; without the macro, the state stays SET_H.
